axi4_lite_slave: RTL and testbench

AXI4-Lite subordinate (responder) terminating the bus driven by the team's AXI4-Lite master. It holds a bank of NUM_REGS memory-mapped registers. Write address and write data are accepted independently and in either order, with byte-strobe writes and a B response. Read and write channels run concurrently through two independent state machines, and out-of-range accesses are flagged.

---
 rtl/axi4_lite_pkg.sv | 27 ++
 rtl/axi4_lite_slave_if.sv | 37 +++
 rtl/axi4_lite_regfile.sv | 53 +++++
 rtl/axi4_lite_slave.sv | 212 +++++++++++++++++++++
 tb/tb_axi4_lite_slave.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes,
// write/read state encodings and the response selection helper.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_WAIT_DATA = 2'd1,
    WR_WAIT_ADDR = 2'd2,
    WR_RESP      = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_DATA = 2'd1
  } rd_state_e;

  // Out-of-range accesses only report SLVERR when error responses are enabled.
  function automatic logic [1:0] range_resp(input logic in_range, input logic err_en);
    return (err_en && !in_range) ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle between the team's master and the register slave.
interface axi4_lite_slave_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0]  S_AXI_AWADDR;
  logic                      S_AXI_AWVALID;
  logic                      S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                      S_AXI_WVALID;
  logic                      S_AXI_WREADY;
  logic [1:0]                S_AXI_BRESP;
  logic                      S_AXI_BVALID;
  logic                      S_AXI_BREADY;
  logic [ADDRESS_WIDTH-1:0]  S_AXI_ARADDR;
  logic                      S_AXI_ARVALID;
  logic                      S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                S_AXI_RRESP;
  logic                      S_AXI_RVALID;
  logic                      S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi4_lite_regfile.sv
// NUM_REGS x DATA_WIDTH register bank: one byte-strobed write port, one
// combinational read port, and in-range flags for both indices.
module axi4_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = 30
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_index,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    wr_in_range,
  input  logic [IDX_W-1:0]        rd_index,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_in_range
);

  logic [DATA_WIDTH-1:0] mem_reg [NUM_REGS];
  logic [DATA_WIDTH-1:0] wr_mask;

  // Expand each strobe bit to a byte-wide bit mask.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_lane
      assign wr_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
    end
  endgenerate

  assign wr_in_range = (wr_index < IDX_W'(NUM_REGS));
  assign rd_in_range = (rd_index < IDX_W'(NUM_REGS));

  // Storage update: only strobed lanes of the addressed register change.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) mem_reg[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_index == IDX_W'(i)) mem_reg[i] <= (mem_reg[i] & ~wr_mask) | (wr_data & wr_mask);
      end
    end
  end

  // Read mux; indices with no backing register read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_index == IDX_W'(i)) rd_data = mem_reg[i];
    end
  end

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite register slave. Independent write and read state machines in
// front of an axi4_lite_regfile. Build option AXIL_SLAVE_ERR_RESP_EN makes
// out-of-range accesses answer SLVERR instead of OKAY.
module axi4_lite_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  axi4_lite_slave_if.slave  s_axi
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDRESS_WIDTH - ADDR_LSB;
`ifdef AXIL_SLAVE_ERR_RESP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  wr_state_e             wr_state_reg, wr_state_next;
  logic                  awready_reg, awready_next, wready_reg, wready_next;
  logic                  bvalid_reg, bvalid_next;
  logic [1:0]            bresp_reg, bresp_next;
  logic [IDX_W-1:0]      aw_index_reg, aw_index_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [STRB_W-1:0]     wstrb_reg, wstrb_next;

  rd_state_e             rd_state_reg, rd_state_next;
  logic                  arready_reg, arready_next, rvalid_reg, rvalid_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic [1:0]            rresp_reg, rresp_next;

  logic                  commit, wr_en, wr_in_range, rd_in_range;
  logic [IDX_W-1:0]      wr_index, aw_index_in, rd_index;
  logic [DATA_WIDTH-1:0] wr_data, rd_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  aw_hs, w_hs, ar_hs;

  assign aw_index_in = s_axi.S_AXI_AWADDR[ADDRESS_WIDTH-1:ADDR_LSB];
  assign rd_index    = s_axi.S_AXI_ARADDR[ADDRESS_WIDTH-1:ADDR_LSB];
  assign aw_hs = s_axi.S_AXI_AWVALID && awready_reg;
  assign w_hs  = s_axi.S_AXI_WVALID  && wready_reg;
  assign ar_hs = s_axi.S_AXI_ARVALID && arready_reg;
  assign wr_en = commit && wr_in_range;

  axi4_lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .wr_en       (wr_en),
    .wr_index    (wr_index),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .wr_in_range (wr_in_range),
    .rd_index    (rd_index),
    .rd_data     (rd_data),
    .rd_in_range (rd_in_range)
  );

  // Write channel: next state, readies, response and commit selection.
  always_comb begin
    wr_state_next = wr_state_reg;
    awready_next  = awready_reg;
    wready_next   = wready_reg;
    bvalid_next   = bvalid_reg;
    bresp_next    = bresp_reg;
    aw_index_next = aw_index_reg;
    wdata_next    = wdata_reg;
    wstrb_next    = wstrb_reg;
    commit        = 1'b0;
    wr_index      = aw_index_reg;
    wr_data       = wdata_reg;
    wr_strb       = wstrb_reg;
    case (wr_state_reg)
      WR_IDLE: begin
        awready_next = 1'b1;
        wready_next  = 1'b1;
        if (aw_hs && w_hs) begin
          commit   = 1'b1;
          wr_index = aw_index_in;
          wr_data  = s_axi.S_AXI_WDATA;
          wr_strb  = s_axi.S_AXI_WSTRB;
        end else if (aw_hs) begin
          aw_index_next = aw_index_in;
          awready_next  = 1'b0;
          wr_state_next = WR_WAIT_DATA;
        end else if (w_hs) begin
          wdata_next    = s_axi.S_AXI_WDATA;
          wstrb_next    = s_axi.S_AXI_WSTRB;
          wready_next   = 1'b0;
          wr_state_next = WR_WAIT_ADDR;
        end
      end
      WR_WAIT_DATA: begin
        if (w_hs) begin
          commit  = 1'b1;
          wr_data = s_axi.S_AXI_WDATA;
          wr_strb = s_axi.S_AXI_WSTRB;
        end
      end
      WR_WAIT_ADDR: begin
        if (aw_hs) begin
          commit   = 1'b1;
          wr_index = aw_index_in;
        end
      end
      WR_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          bvalid_next   = 1'b0;
          awready_next  = 1'b1;
          wready_next   = 1'b1;
          wr_state_next = WR_IDLE;
        end
      end
      default: wr_state_next = WR_IDLE;
    endcase
    if (commit) begin
      wr_state_next = WR_RESP;
      awready_next  = 1'b0;
      wready_next   = 1'b0;
      bvalid_next   = 1'b1;
      bresp_next    = range_resp(wr_in_range, ERR_EN);
    end
  end

  // Write channel registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_reg <= WR_IDLE;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      aw_index_reg <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      awready_reg  <= awready_next;
      wready_reg   <= wready_next;
      bvalid_reg   <= bvalid_next;
      bresp_reg    <= bresp_next;
      aw_index_reg <= aw_index_next;
      wdata_reg    <= wdata_next;
      wstrb_reg    <= wstrb_next;
    end
  end

  // Read channel: capture the addressed register on AR, hold until R accepted.
  always_comb begin
    rd_state_next = rd_state_reg;
    arready_next  = arready_reg;
    rvalid_next   = rvalid_reg;
    rdata_next    = rdata_reg;
    rresp_next    = rresp_reg;
    case (rd_state_reg)
      RD_IDLE: begin
        arready_next = 1'b1;
        if (ar_hs) begin
          rdata_next    = rd_in_range ? rd_data : '0;
          rresp_next    = range_resp(rd_in_range, ERR_EN);
          arready_next  = 1'b0;
          rvalid_next   = 1'b1;
          rd_state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          rvalid_next   = 1'b0;
          arready_next  = 1'b1;
          rd_state_next = RD_IDLE;
        end
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  // Read channel registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_reg <= RD_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
      rresp_reg    <= RESP_OKAY;
    end else begin
      rd_state_reg <= rd_state_next;
      arready_reg  <= arready_next;
      rvalid_reg   <= rvalid_next;
      rdata_reg    <= rdata_next;
      rresp_reg    <= rresp_next;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_reg;
  assign s_axi.S_AXI_WREADY  = wready_reg;
  assign s_axi.S_AXI_BVALID  = bvalid_reg;
  assign s_axi.S_AXI_BRESP   = bresp_reg;
  assign s_axi.S_AXI_ARREADY = arready_reg;
  assign s_axi.S_AXI_RVALID  = rvalid_reg;
  assign s_axi.S_AXI_RDATA   = rdata_reg;
  assign s_axi.S_AXI_RRESP   = rresp_reg;

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed self-checking bench for axi4_lite_slave (NUM_REGS=16, 32-bit data).
module tb_axi4_lite_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
`ifdef AXIL_SLAVE_ERR_RESP_EN
  localparam logic [1:0] ERR_EXP = 2'b10;
`else
  localparam logic [1:0] ERR_EXP = 2'b00;
`endif

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  int checks = 0;
  int errors = 0;

  axi4_lite_slave_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_slave #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s_axi   (bus)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output bit timeout);
    bit aw_pend, w_pend, aw_hs, w_hs;
    int n;
    aw_pend = 1; w_pend = 1; n = 0; timeout = 0; resp = 2'bxx;
    bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_hs = aw_pend && bus.S_AXI_AWREADY;
      w_hs  = w_pend && bus.S_AXI_WREADY;
      @(negedge ACLK); n++;
      if (aw_hs) begin aw_pend = 0; bus.S_AXI_AWVALID = 1'b0; end
      if (w_hs) begin w_pend = 0; bus.S_AXI_WVALID = 1'b0; end
    end
    if (aw_pend || w_pend) timeout = 1;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
    if (!bus.S_AXI_BVALID) timeout = 1;
    else begin resp = bus.S_AXI_BRESP; @(negedge ACLK); end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
    $display("write addr=%h data=%h strb=%h resp=%b timeout=%0d", addr, data, strb, resp, timeout);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output bit timeout);
    bit pend, hs;
    int n;
    pend = 1; n = 0; timeout = 0; data = 'x; resp = 2'bxx;
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
    while (pend && n < 20) begin
      hs = bus.S_AXI_ARREADY;
      @(negedge ACLK); n++;
      if (hs) begin pend = 0; bus.S_AXI_ARVALID = 1'b0; end
    end
    if (pend) timeout = 1;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
    if (!bus.S_AXI_RVALID) timeout = 1;
    else begin data = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP; @(negedge ACLK); end
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    $display("read  addr=%h data=%h resp=%b timeout=%0d", addr, data, resp, timeout);
  endtask

  task automatic test_reset();
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0;
    bus.S_AXI_WVALID = 0; bus.S_AXI_BREADY = 0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_RREADY = 0;
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID}); end
    checks++; if ({bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_BRESP} !== 36'h0) begin
      errors++; $display("FAIL reset_payload: got %h want 0", {bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_BRESP}); end
    ARESETN = 1'b1;
    #1;
    checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b000) begin
      errors++; $display("FAIL ready_before_edge: got %b want 000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
    @(negedge ACLK);
    checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
      errors++; $display("FAIL ready_after_edge: got %b want 111", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}); end
  endtask

  task automatic test_simultaneous_write();
    logic [31:0] d; logic [1:0] r; bit to;
    bus.S_AXI_AWADDR = 32'h04; bus.S_AXI_AWVALID = 1; bus.S_AXI_WDATA = 32'hDEADBEEF;
    bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1;
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    $display("write addr=00000004 data=deadbeef strb=f (AW+W same edge)");
    checks++; if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP} !== 3'b100) begin
      errors++; $display("FAIL sim_bvalid_bresp: got %b want 100", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}); end
    checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b00) begin
      errors++; $display("FAIL sim_readies_low: got %b want 00", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}); end
    bus.S_AXI_BREADY = 1;
    @(negedge ACLK);
    bus.S_AXI_BREADY = 0;
    checks++; if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 3'b011) begin
      errors++; $display("FAIL sim_after_b: got %b want 011", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}); end
    do_read(32'h04, d, r, to);
    checks++; if (to) begin errors++; $display("FAIL sim_rd_timeout: got timeout want response"); end
    checks++; if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      errors++; $display("FAIL sim_readback: got %h/%b want deadbeef/00", d, r); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r; bit to;
    bus.S_AXI_WDATA = 32'hCAFEF00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1;
    @(negedge ACLK);
    bus.S_AXI_WVALID = 0;
    checks++; if ({bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID} !== 3'b010) begin
      errors++; $display("FAIL wfirst_after_w: got %b want 010", {bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID}); end
    repeat (2) @(negedge ACLK);
    checks++; if ({bus.S_AXI_WREADY, bus.S_AXI_BVALID} !== 2'b00) begin
      errors++; $display("FAIL wfirst_waiting: got %b want 00", {bus.S_AXI_WREADY, bus.S_AXI_BVALID}); end
    bus.S_AXI_AWADDR = 32'h08; bus.S_AXI_AWVALID = 1;
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 0;
    $display("write addr=00000008 data=cafef00d strb=f (W 3 cycles before AW)");
    checks++; if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP} !== 3'b100) begin
      errors++; $display("FAIL wfirst_bvalid: got %b want 100", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}); end
    bus.S_AXI_BREADY = 1;
    @(negedge ACLK);
    bus.S_AXI_BREADY = 0;
    do_read(32'h08, d, r, to);
    checks++; if (to || d !== 32'hCAFEF00D) begin
      errors++; $display("FAIL wfirst_readback: got %h (timeout=%0d) want cafef00d", d, to); end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r; bit to;
    do_write(32'h04, 32'h11223344, 4'h5, r, to);
    checks++; if (to || r !== 2'b00) begin
      errors++; $display("FAIL strb_bresp: got %b (timeout=%0d) want 00", r, to); end
    do_read(32'h04, d, r, to);
    checks++; if (to || d !== 32'hDE22BE44) begin
      errors++; $display("FAIL strb_readback: got %h want de22be44", d); end
    do_write(32'h04, 32'hFFFFFFFF, 4'h0, r, to);
    checks++; if (to || r !== 2'b00) begin
      errors++; $display("FAIL strb0_bresp: got %b (timeout=%0d) want 00", r, to); end
    do_read(32'h04, d, r, to);
    checks++; if (to || d !== 32'hDE22BE44) begin
      errors++; $display("FAIL strb0_readback: got %h want de22be44", d); end
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] d; logic [1:0] r; bit to;
    // Write stalled by BREADY low while a second request waits.
    bus.S_AXI_AWADDR = 32'h0C; bus.S_AXI_AWVALID = 1; bus.S_AXI_WDATA = 32'h55AA55AA;
    bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1;
    @(negedge ACLK);
    bus.S_AXI_AWADDR = 32'h10; bus.S_AXI_WDATA = 32'h99999999;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 5'b10000) begin
        errors++; $display("FAIL bstall_cycle%0d: got %b want 10000", k, {bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}); end
      @(negedge ACLK);
    end
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_BREADY = 1;
    @(negedge ACLK);
    bus.S_AXI_BREADY = 0;
    $display("write addr=0000000c data=55aa55aa strb=f (BREADY stalled 5 cycles)");
    do_read(32'h10, d, r, to);
    checks++; if (to || d !== 32'h0) begin
      errors++; $display("FAIL bstall_no_accept: got %h want 00000000", d); end
    // Read stalled by RREADY low while another AR waits.
    bus.S_AXI_ARADDR = 32'h0C; bus.S_AXI_ARVALID = 1;
    @(negedge ACLK);
    bus.S_AXI_ARADDR = 32'h04;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RRESP, bus.S_AXI_RDATA} !== {4'b1000, 32'h55AA55AA}) begin
        errors++; $display("FAIL rstall_cycle%0d: got %b/%b/%h want 1/0/55aa55aa", k, bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RDATA); end
      @(negedge ACLK);
    end
    bus.S_AXI_ARVALID = 0; bus.S_AXI_RREADY = 1;
    @(negedge ACLK);
    bus.S_AXI_RREADY = 0;
    $display("read  addr=0000000c data=55aa55aa (RREADY stalled 5 cycles)");
    checks++; if ({bus.S_AXI_RVALID, bus.S_AXI_ARREADY} !== 2'b01) begin
      errors++; $display("FAIL rstall_release: got %b want 01", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY}); end
    // Read and write of the same register on the same edge: old value returned.
    bus.S_AXI_AWADDR = 32'h14; bus.S_AXI_AWVALID = 1; bus.S_AXI_WDATA = 32'h12345678;
    bus.S_AXI_WVALID = 1; bus.S_AXI_ARADDR = 32'h14; bus.S_AXI_ARVALID = 1;
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_ARVALID = 0;
    $display("write+read addr=00000014 data=12345678 same edge");
    checks++; if ({bus.S_AXI_RVALID, bus.S_AXI_BVALID, bus.S_AXI_RDATA} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL rw_same_edge: got %b%b/%h want 11/00000000", bus.S_AXI_RVALID, bus.S_AXI_BVALID, bus.S_AXI_RDATA); end
    bus.S_AXI_BREADY = 1; bus.S_AXI_RREADY = 1;
    @(negedge ACLK);
    bus.S_AXI_BREADY = 0; bus.S_AXI_RREADY = 0;
    do_read(32'h14, d, r, to);
    checks++; if (to || d !== 32'h12345678) begin
      errors++; $display("FAIL rw_same_edge_after: got %h want 12345678", d); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; bit to;
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, r, to);
    checks++; if (to || r !== ERR_EXP) begin
      errors++; $display("FAIL oor_bresp: got %b (timeout=%0d) want %b", r, to, ERR_EXP); end
    do_read(32'h40, d, r, to);
    checks++; if (to || r !== ERR_EXP || d !== 32'h0) begin
      errors++; $display("FAIL oor_read: got %h/%b want 00000000/%b", d, r, ERR_EXP); end
    do_read(32'h00, d, r, to);
    checks++; if (to || r !== 2'b00 || d !== 32'h0) begin
      errors++; $display("FAIL oor_no_alias: got %h/%b want 00000000/00", d, r); end
    do_read(32'h06, d, r, to);
    checks++; if (to || r !== 2'b00 || d !== 32'hDE22BE44) begin
      errors++; $display("FAIL misaligned_read: got %h/%b want de22be44/00", d, r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; bit to;
    bus.S_AXI_AWADDR = 32'h18; bus.S_AXI_AWVALID = 1;
    @(negedge ACLK);
    bus.S_AXI_AWVALID = 0;
    checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY} !== 2'b01) begin
      errors++; $display("FAIL midrst_aw_taken: got %b want 01", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}); end
    ARESETN = 1'b0;
    #1;
    checks++; if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID} !== 5'b0) begin
      errors++; $display("FAIL midrst_outputs: got %b want 00000", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID, bus.S_AXI_RVALID}); end
    bus.S_AXI_WDATA = 32'hA5A5A5A5; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1;
    @(negedge ACLK);
    bus.S_AXI_WVALID = 0;
    ARESETN = 1'b1;
    @(negedge ACLK);
    $display("reset pulsed between AW and W at addr=00000018");
    do_read(32'h18, d, r, to);
    checks++; if (to || d !== 32'h0) begin
      errors++; $display("FAIL midrst_target: got %h want 00000000", d); end
    do_read(32'h04, d, r, to);
    checks++; if (to || d !== 32'h0) begin
      errors++; $display("FAIL midrst_regs_cleared: got %h want 00000000", d); end
    do_write(32'h18, 32'h0BADF00D, 4'hF, r, to);
    checks++; if (to || r !== 2'b00) begin
      errors++; $display("FAIL midrst_next_write: got %b want 00", r); end
    do_read(32'h18, d, r, to);
    checks++; if (to || d !== 32'h0BADF00D) begin
      errors++; $display("FAIL midrst_next_readback: got %h want 0badf00d", d); end
  endtask

  initial begin
    test_reset();
    test_simultaneous_write();
    test_w_before_aw();
    test_strobe();
    test_back_to_back_stall();
    test_out_of_range();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
